// File: rtl/board_renderer.sv
// -----------------------------------------------------------------------------
// board_renderer
// Pixel generator for the grid-game VGA display.
//   * While vsync is low it reads ROWS*COLS two-bit cell codes from data memory
//     into a shadow buffer, then copies the shadow into the display buffer in a
//     single cycle, so a half-loaded board is never drawn.
//   * Every cycle it colours one pixel from hcount/vcount: the drop-marker strip
//     at the top, the board cells, and the background.
//
// Ports
//   clk          in   pixel clock, one pixel per cycle
//   reset        in   synchronous, active-high
//   bright       in   visible-area flag from the VGA timing controller
//   hcount       in   horizontal counter (visible x = hcount - H_OFFSET)
//   vcount       in   vertical counter   (visible y = vcount)
//   vsync        in   vertical sync, active low; its falling edge starts a fetch
//   mem_data     in   memory read data, valid one cycle after mem_rd
//   column_no    in   column under the drop marker, 0..COLS-1 (else no marker)
//   player       in   current player, bits [1:0] select the marker colour
//   mem_addr     out  memory read address
//   mem_rd       out  memory read strobe
//   rgb          out  pixel colour {b,g,r}, registered, one cycle after inputs
//   frame_ready  out  one-cycle pulse when a new board is swapped in
//   fetch_abort  out  one-cycle pulse when vsync rises before the fetch ends
// -----------------------------------------------------------------------------
module board_renderer #(
  parameter int ROWS      = 6,
  parameter int COLS      = 7,
  parameter int CELL      = 50,
  parameter int GAP_X     = 36,
  parameter int GAP_Y     = 10,
  parameter int ORIGIN_X  = 36,
  parameter int ORIGIN_Y  = 110,
  parameter int H_OFFSET  = 158,
  parameter int BASE_ADDR = 2048,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bright,
  input  logic [9:0]        hcount,
  input  logic [9:0]        vcount,
  input  logic              vsync,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [15:0]       column_no,
  input  logic [15:0]       player,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [23:0]       rgb,
  output logic              frame_ready,
  output logic              fetch_abort
);

  localparam int NCELL   = ROWS * COLS;
  localparam int KW      = $clog2(NCELL + 1);
  localparam int PITCH_X = CELL + GAP_X;
  localparam int PITCH_Y = CELL + GAP_Y;
  localparam int STRIP_H = 84;
  localparam int MARK_Y0 = 16;
  localparam int MARK_Y1 = 66;

  localparam logic [KW-1:0] K_LAST = KW'(NCELL - 1);

  // Colours are packed {b,g,r}.
  localparam logic [23:0] C_BLACK   = {8'd0,   8'd0,   8'd0};
  localparam logic [23:0] C_GREY    = {8'd96,  8'd96,  8'd96};
  localparam logic [23:0] C_RED     = {8'd0,   8'd0,   8'd255};
  localparam logic [23:0] C_YELLOW  = {8'd0,   8'd255, 8'd255};
  localparam logic [23:0] C_MAGENTA = {8'd255, 8'd0,   8'd255};
  localparam logic [23:0] C_BG      = {8'd255, 8'd204, 8'd153};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_SWAP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [KW-1:0]       r_k;
  logic [KW-1:0]       w_k_nxt;
  logic                w_abort;
  logic                r_vsync_d;
  logic                w_vsync_fall;

  logic                r_mem_rd;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic                r_frame_ready;
  logic                r_fetch_abort;

  // Capture pipeline: index of the read issued last cycle, whose data is on
  // mem_data this cycle.
  logic                r_cap_en;
  logic [KW-1:0]       r_cap_idx;

  logic [2*NCELL-1:0]  r_shadow;
  logic [2*NCELL-1:0]  r_display;

  int                  w_x;
  int                  w_y;
  logic                w_col_hit;
  logic                w_row_hit;
  int                  w_col_idx;
  int                  w_row_idx;
  int                  w_cell_idx;
  logic [1:0]          w_code;
  logic                w_mark_on;
  int                  w_mark_x0;
  logic [23:0]         w_mark_col;
  logic [23:0]         w_pix;
  logic [23:0]         r_rgb;

  // Upper memory bits and upper player bits carry no information here.
  logic                w_unused;
  assign w_unused = ^{mem_data[DATA_W-1:2], player[15:2]};

  assign w_vsync_fall = r_vsync_d & ~vsync;

  // Fetch FSM next-state and cell-index logic.
  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_vsync_fall) begin
          w_state_nxt = S_FETCH;
          w_k_nxt     = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (vsync) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (r_k == K_LAST) begin
          w_state_nxt = S_DRAIN;
          w_k_nxt     = r_k + KW'(1);
        end else begin
          w_state_nxt = S_FETCH;
          w_k_nxt     = r_k + KW'(1);
        end
      end
      S_DRAIN: begin
        if (vsync) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_SWAP;
        end
      end
      S_SWAP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_k_nxt     = '0;
      end
    endcase
  end

  // FSM state, fetch strobes and status pulses. mem_rd/mem_addr are registered
  // from the next state, so they are high exactly during the FETCH cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_k           <= '0;
      r_vsync_d     <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_addr    <= ADDR_W'(BASE_ADDR);
      r_frame_ready <= 1'b0;
      r_fetch_abort <= 1'b0;
      r_cap_en      <= 1'b0;
      r_cap_idx     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_k           <= w_k_nxt;
      r_vsync_d     <= vsync;
      r_mem_rd      <= (w_state_nxt == S_FETCH);
      r_mem_addr    <= (w_state_nxt == S_FETCH) ?
                       (ADDR_W'(BASE_ADDR) + ADDR_W'(w_k_nxt)) :
                       ADDR_W'(BASE_ADDR);
      r_frame_ready <= (r_state == S_SWAP);
      r_fetch_abort <= w_abort;
      r_cap_en      <= (r_state == S_FETCH);
      r_cap_idx     <= r_k;
    end
  end

  // Shadow buffer: store the code returned for the read issued last cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shadow <= '0;
    end else if (r_cap_en) begin
      r_shadow[2*int'(r_cap_idx) +: 2] <= mem_data[1:0];
    end else begin
      r_shadow <= r_shadow;
    end
  end

  // Display buffer: whole-board copy in the SWAP cycle, aligned with frame_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_display <= '0;
    end else if (r_state == S_SWAP) begin
      r_display <= r_shadow;
    end else begin
      r_display <= r_display;
    end
  end

  // Pixel colour from the current coordinates and the display buffer.
  always_comb begin
    w_x        = int'(hcount) - H_OFFSET;
    w_y        = int'(vcount);
    w_col_hit  = 1'b0;
    w_row_hit  = 1'b0;
    w_col_idx  = 0;
    w_row_idx  = 0;

    // Column / screen-row hit tests; left/top inclusive, right/bottom exclusive.
    for (int c = 0; c < COLS; c++) begin
      w_col_hit = w_col_hit |
                  ((w_x >= ORIGIN_X + c*PITCH_X) && (w_x < ORIGIN_X + c*PITCH_X + CELL));
      w_col_idx = ((w_x >= ORIGIN_X + c*PITCH_X) && (w_x < ORIGIN_X + c*PITCH_X + CELL)) ?
                  c : w_col_idx;
    end
    for (int s = 0; s < ROWS; s++) begin
      w_row_hit = w_row_hit |
                  ((w_y >= ORIGIN_Y + s*PITCH_Y) && (w_y < ORIGIN_Y + s*PITCH_Y + CELL));
      w_row_idx = ((w_y >= ORIGIN_Y + s*PITCH_Y) && (w_y < ORIGIN_Y + s*PITCH_Y + CELL)) ?
                  s : w_row_idx;
    end

    // Screen row 0 is the top of the board, i.e. board row ROWS-1.
    w_cell_idx = (ROWS - 1 - w_row_idx) * COLS + w_col_idx;
    w_code     = r_display[2*w_cell_idx +: 2];

    // The marker row spans y = 16..66 inclusive.
    w_mark_x0  = ORIGIN_X + int'(column_no) * PITCH_X;
    w_mark_on  = (int'(column_no) < COLS) &&
                 (w_y >= MARK_Y0) && (w_y <= MARK_Y1) &&
                 (w_x >= w_mark_x0) && (w_x < w_mark_x0 + CELL);
    w_mark_col = (player[1:0] == 2'd2) ? C_YELLOW : C_RED;

    if (!bright) begin
      w_pix = C_BLACK;
    end else if (w_y < STRIP_H) begin
      w_pix = w_mark_on ? w_mark_col : C_GREY;
    end else if (w_col_hit && w_row_hit) begin
      case (w_code)
        2'd0:    w_pix = C_GREY;
        2'd1:    w_pix = C_RED;
        2'd2:    w_pix = C_YELLOW;
        2'd3:    w_pix = C_MAGENTA;
        default: w_pix = C_GREY;
      endcase
    end else begin
      w_pix = C_BG;
    end
  end

  // Output pixel register: one cycle of latency from hcount/vcount/bright.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb <= C_BLACK;
    end else begin
      r_rgb <= w_pix;
    end
  end

  assign mem_addr    = r_mem_addr;
  assign mem_rd      = r_mem_rd;
  assign rgb         = r_rgb;
  assign frame_ready = r_frame_ready;
  assign fetch_abort = r_fetch_abort;

endmodule

// File: tb/tb_board_renderer.sv
module tb_board_renderer;

  localparam logic [23:0] GREY    = 24'h606060;
  localparam logic [23:0] RED     = 24'h0000FF;
  localparam logic [23:0] YELLOW  = 24'h00FFFF;
  localparam logic [23:0] MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BG      = 24'hFFCC99;

  logic        clk = 1'b0;
  logic        reset;
  logic        bright;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        vsync;
  logic [15:0] column_no;
  logic [15:0] player;

  logic [15:0] mem_data1 = 16'h0000;
  logic [11:0] mem_addr1;
  logic        mem_rd1;
  logic [23:0] rgb1;
  logic        frame_ready1;
  logic        fetch_abort1;

  logic [15:0] mem_data2 = 16'h0000;
  logic [11:0] mem_addr2;
  logic        mem_rd2;
  logic [23:0] rgb2;
  logic        frame_ready2;
  logic        fetch_abort2;

  logic        all3 = 1'b0;

  int checks = 0;
  int errors = 0;

  int rd1, first1, last1, gaps1, badaddr1, fr1, frc1, ab1;
  int rd2, first2, last2, gaps2, badaddr2, fr2, frc2, ab2;

  always #5 clk = ~clk;

  board_renderer dut1 (
    .clk(clk), .reset(reset), .bright(bright), .hcount(hcount), .vcount(vcount),
    .vsync(vsync), .mem_data(mem_data1), .column_no(column_no), .player(player),
    .mem_addr(mem_addr1), .mem_rd(mem_rd1), .rgb(rgb1),
    .frame_ready(frame_ready1), .fetch_abort(fetch_abort1)
  );

  board_renderer #(.ROWS(4), .COLS(5), .CELL(20)) dut2 (
    .clk(clk), .reset(reset), .bright(bright), .hcount(hcount), .vcount(vcount),
    .vsync(vsync), .mem_data(mem_data2), .column_no(column_no), .player(player),
    .mem_addr(mem_addr2), .mem_rd(mem_rd2), .rgb(rgb2),
    .frame_ready(frame_ready2), .fetch_abort(fetch_abort2)
  );

  // Memory 1: code (k mod 3), or all 3 when all3 is set; junk in upper bits.
  function automatic logic [15:0] mem1_word(input logic [11:0] a);
    int k;
    k = int'(a) - 2048;
    if (all3) return 16'hA5C3;
    return 16'hA5C0 | 16'(k % 3);
  endfunction

  // Memory 2: code ((k+3) mod 4).
  function automatic logic [15:0] mem2_word(input logic [11:0] a);
    int k;
    k = int'(a) - 2048;
    return 16'h5A30 | 16'((k + 3) % 4);
  endfunction

  always @(posedge clk) begin
    mem_data1 <= mem1_word(mem_addr1);
    mem_data2 <= mem2_word(mem_addr2);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    rd1 = 0; first1 = -1; last1 = -1; gaps1 = 0; badaddr1 = 0; fr1 = 0; frc1 = -1; ab1 = 0;
    rd2 = 0; first2 = -1; last2 = -1; gaps2 = 0; badaddr2 = 0; fr2 = 0; frc2 = -1; ab2 = 0;
  endtask

  // Run n cycles, logging read strobes, addresses and status pulses.
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (mem_rd1) begin
        if (rd1 == 0) first1 = i;
        else if (i != last1 + 1) gaps1++;
        if (mem_addr1 !== 12'(2048 + rd1)) badaddr1++;
        last1 = i;
        rd1++;
      end
      if (frame_ready1) begin fr1++; frc1 = i; end
      if (fetch_abort1) ab1++;
      if (mem_rd2) begin
        if (rd2 == 0) first2 = i;
        else if (i != last2 + 1) gaps2++;
        if (mem_addr2 !== 12'(2048 + rd2)) badaddr2++;
        last2 = i;
        rd2++;
      end
      if (frame_ready2) begin fr2++; frc2 = i; end
      if (fetch_abort2) ab2++;
    end
  endtask

  // Present a visible pixel (x,y) and let the output register take it.
  task automatic px(input int x, input int y);
    hcount = 10'(x + 158);
    vcount = 10'(y);
    tick();
  endtask

  initial begin
    reset = 1'b1; bright = 1'b1; vsync = 1'b1;
    column_no = 16'd7; player = 16'd1;
    hcount = 10'(36 + 158); vcount = 10'd410;

    // Reset
    tick(); tick(); tick();
    check("rst_rgb", 32'(rgb1), 32'h0);
    check("rst_mem_rd", 32'(mem_rd1), 32'h0);
    check("rst_mem_addr", 32'(mem_addr1), 32'd2048);
    check("rst_frame_ready", 32'(frame_ready1), 32'h0);
    check("rst_fetch_abort", 32'(fetch_abort1), 32'h0);
    reset = 1'b0;
    tick();
    check("post_rst_cell00", 32'(rgb1), 32'(GREY));
    tick();

    // Full fetch
    clear_counts();
    vsync = 1'b0;
    watch(100);
    check("fetch_reads", 32'(rd1), 32'd42);
    check("fetch_first_cycle", 32'(first1), 32'd0);
    check("fetch_gaps", 32'(gaps1), 32'd0);
    check("fetch_bad_addr", 32'(badaddr1), 32'd0);
    check("fetch_frame_ready_cnt", 32'(fr1), 32'd1);
    check("fetch_frame_ready_lat", 32'(frc1 - first1), 32'd44);
    check("fetch_abort_cnt", 32'(ab1), 32'd0);
    check("p2_reads", 32'(rd2), 32'd20);
    check("p2_gaps", 32'(gaps2), 32'd0);
    check("p2_bad_addr", 32'(badaddr2), 32'd0);
    check("p2_frame_ready_lat", 32'(frc2 - first2), 32'd22);
    vsync = 1'b1;
    watch(5);

    // Board pixels
    px(36, 110);  check("cell_r5c0", 32'(rgb1), 32'(YELLOW));
    px(85, 110);  check("cell_r5c0_right_in", 32'(rgb1), 32'(YELLOW));
    px(86, 110);  check("cell_r5c0_right_out", 32'(rgb1), 32'(BG));
    px(36, 159);  check("cell_r5c0_bottom_in", 32'(rgb1), 32'(YELLOW));
    px(36, 160);  check("cell_r5c0_bottom_out", 32'(rgb1), 32'(BG));
    px(36, 410);  check("cell_r0c0", 32'(rgb1), 32'(GREY));
    px(35, 410);  check("cell_r0c0_left_out", 32'(rgb1), 32'(BG));
    px(122, 410); check("cell_r0c1", 32'(rgb1), 32'(RED));
    px(36 + 4*56, 110 + 3*30); check("p2_cell_r0c4", 32'(rgb2), 32'(MAGENTA));
    px(36 + 3*56, 110 + 3*30); check("p2_cell_r0c3", 32'(rgb2), 32'(YELLOW));

    // Marker strip
    column_no = 16'd3; player = 16'd2;
    px(36 + 3*86, 16);      check("mark_c3_yellow", 32'(rgb1), 32'(YELLOW));
    px(36 + 3*86 + 50, 16); check("mark_c3_right_out", 32'(rgb1), 32'(GREY));
    px(36 + 3*86 - 1, 16);  check("mark_c3_left_out", 32'(rgb1), 32'(GREY));
    px(36 + 3*86, 66);      check("mark_y66_in", 32'(rgb1), 32'(YELLOW));
    px(36 + 3*86, 67);      check("mark_y67_out", 32'(rgb1), 32'(GREY));
    px(36 + 3*86, 15);      check("mark_y15_out", 32'(rgb1), 32'(GREY));
    player = 16'd1;
    px(36 + 3*86, 40);      check("mark_player1_red", 32'(rgb1), 32'(RED));
    player = 16'd0;
    px(36 + 3*86, 40);      check("mark_player0_red", 32'(rgb1), 32'(RED));
    player = 16'd2; column_no = 16'd6;
    px(36 + 6*86, 40);      check("mark_c6_yellow", 32'(rgb1), 32'(YELLOW));
    column_no = 16'd7;
    px(36 + 6*86, 40);      check("mark_c7_none_c6pos", 32'(rgb1), 32'(GREY));
    px(36 + 3*86, 40);      check("mark_c7_none_c3pos", 32'(rgb1), 32'(GREY));

    // Latency and blanking
    px(10, 300);            check("bg_pixel", 32'(rgb1), 32'(BG));
    bright = 1'b0;
    #1;                     check("blank_before_edge", 32'(rgb1), 32'(BG));
    tick();                 check("blank_after_edge", 32'(rgb1), 32'h0);
    bright = 1'b1;

    // Abort: new pattern is fetched partially and must not appear
    all3 = 1'b1;
    clear_counts();
    vsync = 1'b0;
    watch(20);
    vsync = 1'b1;
    watch(10);
    check("abort_cnt", 32'(ab1), 32'd1);
    check("abort_frame_ready", 32'(fr1), 32'd0);
    check("p2_abort_cnt", 32'(ab2), 32'd1);
    check("p2_abort_frame_ready", 32'(fr2), 32'd0);
    px(36, 110);            check("abort_display_kept", 32'(rgb1), 32'(YELLOW));

    // Next full vsync completes with the new pattern
    clear_counts();
    vsync = 1'b0;
    watch(100);
    check("refetch_reads", 32'(rd1), 32'd42);
    check("refetch_bad_addr", 32'(badaddr1), 32'd0);
    check("refetch_frame_ready", 32'(fr1), 32'd1);
    check("refetch_abort", 32'(ab1), 32'd0);
    vsync = 1'b1;
    watch(3);
    px(36, 110);            check("refetch_r5c0", 32'(rgb1), 32'(MAGENTA));
    px(36, 410);            check("refetch_r0c0", 32'(rgb1), 32'(MAGENTA));

    // Reset in the middle of a fetch
    all3 = 1'b0;
    vsync = 1'b0;
    watch(10);
    reset = 1'b1;
    tick();
    check("midrst_mem_rd", 32'(mem_rd1), 32'h0);
    check("midrst_mem_addr", 32'(mem_addr1), 32'd2048);
    check("midrst_rgb", 32'(rgb1), 32'h0);
    reset = 1'b0;
    vsync = 1'b1;
    clear_counts();
    watch(60);
    check("midrst_no_reads", 32'(rd1), 32'd0);
    check("midrst_no_frame", 32'(fr1), 32'd0);
    px(36, 110);            check("midrst_display_cleared", 32'(rgb1), 32'(GREY));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
